// File: rtl/alu_seq_if.sv
// Operand-issue / result-writeback handshake bundle for alu_seq.
// The issuer drives the master side and the ALU implements the slave side.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           alu_code;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 flag_c;
  logic                 flag_z;

  modport master (
    output in_valid, alu_code, a, b, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z
  );

  modport slave (
    input  in_valid, alu_code, a, b, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic ops and a WIDTH-cycle shift-add
// multiply, returning a registered 2*WIDTH-bit result with carry and zero flags.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_seq_if.slave bus
);
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  state_t          r_state;
  state_t          w_next;
  logic [RW-1:0]   r_result;
  logic            r_flag_c;
  logic            r_flag_z;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_last;
  logic [WIDTH:0]  w_sum;
  logic [WIDTH:0]  w_diff;
  logic [RW-1:0]   w_res;
  logic            w_c;
  logic [RW-1:0]   w_acc_next;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_is_mul = (op_t'(bus.alu_code) == OP_MUL);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  assign bus.result = r_result;
  assign bus.flag_c = r_flag_c;
  assign bus.flag_z = r_flag_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (w_accept) begin
          w_next = w_is_mul ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle ops; operands are extended one bit so carry/borrow fall out of bit WIDTH.
  always_comb begin
    w_res  = '0;
    w_c    = 1'b0;
    w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    case (op_t'(bus.alu_code))
      OP_ADD: begin
        w_res = RW'(w_sum);
        w_c   = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res = RW'(w_diff[WIDTH-1:0]);
        w_c   = w_diff[WIDTH];
      end
      OP_AND: w_res = RW'(bus.a & bus.b);
      OP_OR:  w_res = RW'(bus.a | bus.b);
      OP_XOR: w_res = RW'(bus.a ^ bus.b);
      OP_SHL: begin
        w_res = RW'({bus.a[WIDTH-2:0], 1'b0});
        w_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = RW'({1'b0, bus.a[WIDTH-1:1]});
        w_c   = bus.a[0];
      end
      default: begin
        w_res = '0;
        w_c   = 1'b0;
      end
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + (r_mcand << r_cnt)) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= RW'(bus.a);
      r_mplier <= bus.b;
      r_acc    <= '0;
      r_cnt    <= '0;
      if (!w_is_mul) begin
        r_result <= w_res;
        r_flag_c <= w_c;
        r_flag_z <= (w_res == '0);
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_result <= w_acc_next;
        r_flag_c <= |w_acc_next[RW-1:WIDTH];
        r_flag_z <= (w_acc_next == '0);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at WIDTH=4 plus a WIDTH=8 multiply instance.
module tb_alu_seq;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_seq_if #(.WIDTH(4)) bus4 ();
  alu_seq_if #(.WIDTH(8)) bus8 ();

  alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issues one op on the WIDTH=4 DUT and returns cycles from accept to out_valid.
  task automatic do_op(input logic [2:0] code, input logic [3:0] xa, input logic [3:0] xb,
                       output int lat, output logic busy_ok);
    int n;
    n = 0;
    while (!bus4.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_issue", 16'(bus4.in_ready), 16'd1);
    bus4.alu_code = code;
    bus4.a        = xa;
    bus4.b        = xb;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus4.out_valid && lat < 20) begin
      if (bus4.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic busy_ok;
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{3'b000, 4'hA, 4'h5, 8'h0F, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'b001, 4'hA, 4'h5, 8'h05, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'b010, 4'hA, 4'h5, 8'h32, 1'b1, 1'b0, 5};
    vecs[3]  = '{3'b011, 4'hA, 4'h5, 8'h00, 1'b0, 1'b1, 1};
    vecs[4]  = '{3'b100, 4'hA, 4'h5, 8'h0F, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'b101, 4'hA, 4'h5, 8'h0F, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'b110, 4'hA, 4'h5, 8'h04, 1'b1, 1'b0, 1};
    vecs[7]  = '{3'b111, 4'hA, 4'h5, 8'h05, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'b001, 4'h5, 4'hA, 8'h0B, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'b000, 4'hF, 4'h1, 8'h10, 1'b1, 1'b0, 1};
    vecs[10] = '{3'b010, 4'hF, 4'hF, 8'hE1, 1'b1, 1'b0, 5};
    vecs[11] = '{3'b010, 4'h0, 4'h7, 8'h00, 1'b0, 1'b1, 5};
    vecs[12] = '{3'b010, 4'h3, 4'h2, 8'h06, 1'b0, 1'b0, 5};
    vecs[13] = '{3'b110, 4'h7, 4'h0, 8'h0E, 1'b0, 1'b0, 1};
    vecs[14] = '{3'b111, 4'h1, 4'h0, 8'h00, 1'b1, 1'b1, 1};
    vecs[15] = '{3'b110, 4'h8, 4'h3, 8'h00, 1'b1, 1'b1, 1};

    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.alu_code  = 3'b000;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.alu_code  = 3'b000;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.out_ready = 1'b1;

    #12;
    check("rst_out_valid", 16'(bus4.out_valid), 16'd0);
    check("rst_result",    16'(bus4.result),    16'd0);
    check("rst_flag_c",    16'(bus4.flag_c),    16'd0);
    check("rst_flag_z",    16'(bus4.flag_z),    16'd0);
    check("rst_result8",   bus8.result,         16'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  16'(bus4.in_ready),  16'd1);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].code, vecs[i].a, vecs[i].b, lat, busy_ok);
      check($sformatf("vec%0d_result", i), 16'(bus4.result), 16'(vecs[i].res));
      check($sformatf("vec%0d_flag_c", i), 16'(bus4.flag_c), 16'(vecs[i].c));
      check($sformatf("vec%0d_flag_z", i), 16'(bus4.flag_z), 16'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), 16'(lat), 16'(vecs[i].lat));
      if (vecs[i].code == 3'b010)
        check($sformatf("vec%0d_busy_in_ready_low", i), 16'(busy_ok), 16'd1);
    end

    // WIDTH=8 multiply 0xFF*0xFF
    begin
      int n8;
      logic busy8;
      @(posedge clk); #1;
      check("w8_in_ready", 16'(bus8.in_ready), 16'd1);
      bus8.alu_code = 3'b010;
      bus8.a        = 8'hFF;
      bus8.b        = 8'hFF;
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      n8    = 1;
      busy8 = 1'b1;
      while (!bus8.out_valid && n8 < 30) begin
        if (bus8.in_ready) busy8 = 1'b0;
        @(posedge clk); #1;
        n8++;
      end
      check("w8_mul_latency", 16'(n8), 16'd9);
      check("w8_mul_result", bus8.result, 16'hFE01);
      check("w8_mul_flag_c", 16'(bus8.flag_c), 16'd1);
      check("w8_mul_flag_z", 16'(bus8.flag_z), 16'd0);
      check("w8_mul_busy", 16'(busy8), 16'd1);
    end

    // Backpressure in DONE with in_valid held high
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    do_op(3'b000, 4'h3, 4'h4, lat, busy_ok);
    check("bp_first_result", 16'(bus4.result), 16'h07);
    bus4.alu_code = 3'b000;
    bus4.a        = 4'hF;
    bus4.b        = 4'hF;
    bus4.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", k), 16'(bus4.out_valid), 16'd1);
      check($sformatf("bp%0d_in_ready", k),  16'(bus4.in_ready),  16'd0);
      check($sformatf("bp%0d_result", k),    16'(bus4.result),    16'h07);
      check($sformatf("bp%0d_flag_c", k),    16'(bus4.flag_c),    16'd0);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 16'(bus4.out_valid), 16'd0);
    check("bp_release_in_ready",  16'(bus4.in_ready),  16'd1);
    do_op(3'b100, 4'h1, 4'h2, lat, busy_ok);
    check("bp_next_result",  16'(bus4.result), 16'h03);
    check("bp_next_latency", 16'(lat), 16'd1);

    // Async reset during step 2 of a multiply
    @(posedge clk); #1;
    bus4.alu_code = 3'b010;
    bus4.a        = 4'hA;
    bus4.b        = 4'h5;
    bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mulrst_busy", 16'(bus4.in_ready), 16'd0);
    rst_n = 1'b0;
    #1;
    check("mulrst_out_valid", 16'(bus4.out_valid), 16'd0);
    check("mulrst_result",    16'(bus4.result),    16'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mulrst_in_ready",  16'(bus4.in_ready),  16'd1);
    check("mulrst_idle",      16'(bus4.out_valid), 16'd0);
    do_op(3'b000, 4'h3, 4'h4, lat, busy_ok);
    check("postrst_add_result",  16'(bus4.result), 16'h07);
    check("postrst_add_latency", 16'(lat), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
